wb_ccff_loader: RTL and testbench
=================================

// Module: wb_ccff_loader
// PURPOSE
//  Wishbone slave that streams an FPGA configuration bitstream into the fabric's configuration chain.
//  It sits between the user-area Wishbone decode (the DAC-side strobe, wbs_adr_i[14]=1) and fpga_core.
//  Firmware pushes 32-bit words into a FIFO. The block serialises them MSB-first onto ccff_head and
//  generates prog_clk itself. ccff_tail is captured for readback, so a chain can be verified by loopback.
// PARAMETERS
//  FIFO_DEPTH  8   words of bitstream buffering (power of 2, >=2)
//  DIV_W       8   width of prog_clk half-period divider
//  LEN_W       20  width of chain length (bits) register
// PORTS
//  wb_clk_i      in   1   sole clock
//  wb_rst_ni     in   1   synchronous active-low reset
//  wbs_stb_i     in   1   strobe, pre-qualified for this slave
//  wbs_cyc_i     in   1   bus cycle
//  wbs_we_i      in   1   write enable
//  wbs_sel_i     in   4   byte selects
//  wbs_adr_i     in   32  address; only [3:2] decoded
//  wbs_dat_i     in   32  write data
//  wbs_ack_o     out  1   acknowledge
//  wbs_dat_o     out  32  read data
//  prog_clk_o    out  1   configuration clock to fpga_core
//  ccff_head_o   out  1   serial configuration data to chain head
//  ccff_tail_i   in   1   chain tail, sampled for readback
//  prog_reset_o  out  1   configuration reset, software controlled
//  irq_o         out  1   level = STATUS.done
// BEHAVIOUR
//  Reset (wb_rst_ni=0 at a clock edge): all outputs 0, FIFO empty, DIV=0, LEN=0, TAIL=0, state IDLE.
//  Reset mid-shift abandons the transfer immediately; no further prog_clk edges.
//  Bus: ack_o=1 exactly one cycle after a cycle with stb&cyc&~ack_o, then 0 for one cycle (no back-to-back).
//   Writes commit in the ack cycle. Read data is valid with ack and is 0 otherwise.
//  Register map (adr[3:2]):
//   0 CTRL(W): [0] start, [1] abort, [2] clr_flags, [3] prog_reset level. Bits [2:0] are self-clearing.
//     STATUS(R): [0] busy, [1] done, [2] ovf, [3] prog_reset, [11:8] fifo level, [12] full, [13] empty.
//   1 DATA(W): pushes full 32-bit word, sel ignored. Push when full and no same-cycle pop: word dropped, ovf=1.
//     DATA(R) reads 0.
//   2 CFG(RW): [DIV_W-1:0] DIV, [8+LEN_W-1:8] LEN (bits to shift). Honours byte selects.
//     Write ignored while busy.
//   3 TAIL(R): last 32 ccff_tail samples, newest in bit0. Writes ignored.
//  FIFO: same-cycle push+pop when full is accepted (level unchanged). Pop only in LOAD.
//  FSM: IDLE -> LOAD -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO | LOAD | DONE) -> IDLE.
//   IDLE: start && LEN!=0 -> LOAD, busy=1, remaining=LEN.
//     start && LEN==0 -> done=1 next cycle, no pulses. start while busy ignored.
//   LOAD: FIFO empty -> stall here (underrun), prog_clk_o held 0, no bits lost.
//     Else pop word into shift reg, bitcnt=31 -> SHIFT_LO.
//   SHIFT_LO: ccff_head_o=shreg[31], prog_clk_o=0, for DIV+1 cycles -> SHIFT_HI.
//   SHIFT_HI: prog_clk_o=1 for DIV+1 cycles; ccff_head_o held stable.
//     On entry cycle (rising edge), TAIL<={TAIL[30:0],ccff_tail_i}.
//     On exit, remaining-=1, shreg<<=1. Then:
//       remaining==0 -> DONE; bitcnt==0 -> LOAD; else SHIFT_LO.
//   DONE: one cycle, done=1 (sticky until clr_flags), busy=0 -> IDLE.
//  Partial final word (LEN%32!=0): only its top LEN%32 bits are shifted; the rest are discarded.
//  abort (any state): FIFO flushed, prog_clk_o=0, ccff_head_o=0, busy=0, done unchanged -> IDLE next cycle.
//  prog_clk_o and ccff_head_o are registered outputs; each bit costs 2*(DIV+1) cycles.
//  DIV is read at each phase start.
// TESTING
//  DIV=0, LEN=8, push 0xA5000000, start:
//    8 pulses, period 2 cycles; head=1,0,1,0,0,1,0,1; done=1, irq_o=1.
//  Loopback tail=head, LEN=64, push 0xDEADBEEF,0x12345678, DIV=3:
//    period 8 cycles; TAIL=0x12345678 after done.
//  Start with FIFO empty, push word 20 cycles later:
//    prog_clk_o stays 0 until push; all 32 bits then shifted in order.
//  Push 9 words into depth-8 FIFO while idle:
//    ovf=1, level=8; clr_flags -> ovf=0, level still 8.
//  Abort mid-word at DIV=2, and separately wb_rst_ni=0 mid-shift:
//    prog_clk_o=0 next cycle, empty=1, busy=0; no pulses afterwards.
//  start with LEN=0 and CFG write while busy:
//    done=1 with zero pulses; CFG readback unchanged.

Source files
------------

// File: rtl/wb_ccff_loader.sv
// wb_ccff_loader: Wishbone slave that buffers 32-bit bitstream words in a FIFO
// and shifts them MSB-first onto the fabric configuration chain. It generates
// its own prog_clk and captures the chain tail so the chain can be read back.
//
// Ports:
//   wb_clk_i, wb_rst_ni      clock, synchronous active-low reset
//   wbs_*                    Wishbone slave (adr[3:2] selects CTRL/DATA/CFG/TAIL)
//   prog_clk_o, ccff_head_o  registered configuration clock and serial data
//   ccff_tail_i              chain tail, sampled once per prog_clk rising edge
//   prog_reset_o             software-controlled configuration reset level
//   irq_o                    follows the sticky done flag
module wb_ccff_loader #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned LEN_W      = 20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        prog_clk_o,
    output logic        ccff_head_o,
    input  logic        ccff_tail_i,
    output logic        prog_reset_o,
    output logic        irq_o
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned LEN_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE
    } state_t;

    state_t             state_q, state_nxt;
    logic               ack_q;
    logic [31:0]        dat_q;
    logic [DIV_W-1:0]   div_q;
    logic [LEN_W-1:0]   len_q;
    logic [31:0]        tail_q;
    logic               done_q, ovf_q, preset_q;
    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic [31:0]        shreg_q, shreg_nxt;
    logic [4:0]         bitcnt_q, bitcnt_nxt;
    logic [LEN_W-1:0]   remaining_q, remaining_nxt;
    logic [DIV_W-1:0]   phase_cnt_q, phase_cnt_nxt;
    logic               pclk_q, head_q, hi_entry_q;

    // Bus decode; writes take effect on the edge that ends the ack cycle
    logic        bus_req, wr_commit, busy, empty, full;
    logic        ctrl_wr, data_wr, cfg_wr, start, abort, clr_flags;
    logic        pop, push_ok, done_set;
    logic [31:0] status_word, cfg_img, cfg_mask, cfg_new, rd_mux;
    logic        unused_bits;

    assign bus_req   = wbs_stb_i & wbs_cyc_i;
    assign wr_commit = bus_req & ack_q & wbs_we_i;
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT_LO) || (state_q == ST_SHIFT_HI);
    assign empty     = (level_q == '0);
    assign full      = (level_q == LVL_W'(FIFO_DEPTH));

    assign ctrl_wr   = wr_commit && (wbs_adr_i[3:2] == 2'd0);
    assign data_wr   = wr_commit && (wbs_adr_i[3:2] == 2'd1);
    assign cfg_wr    = wr_commit && (wbs_adr_i[3:2] == 2'd2) && !busy;
    assign start     = ctrl_wr & wbs_dat_i[0];
    assign abort     = ctrl_wr & wbs_dat_i[1];
    assign clr_flags = ctrl_wr & wbs_dat_i[2];

    // A full FIFO still accepts a word when a pop frees a slot in the same cycle
    assign push_ok = data_wr && !abort && (!full || pop);

    assign status_word = {18'd0, empty, full, 4'(level_q), 4'd0, preset_q, ovf_q, done_q, busy};
    assign cfg_img     = 32'(div_q) | (32'(len_q) << LEN_LSB);
    assign cfg_mask    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign cfg_new     = (cfg_img & ~cfg_mask) | (wbs_dat_i & cfg_mask);
    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

    always_comb begin
        rd_mux = 32'd0;
        case (wbs_adr_i[3:2])
            2'd0:    rd_mux = status_word;
            2'd2:    rd_mux = cfg_img;
            2'd3:    rd_mux = tail_q;
            default: rd_mux = 32'd0;
        endcase
    end

    // FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) state_q <= ST_IDLE;
        else            state_q <= state_nxt;
    end

    // FSM next state and shift datapath
    always_comb begin
        state_nxt     = state_q;
        pop           = 1'b0;
        done_set      = 1'b0;
        shreg_nxt     = shreg_q;
        bitcnt_nxt    = bitcnt_q;
        remaining_nxt = remaining_q;
        phase_cnt_nxt = phase_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_q != '0) begin
                        state_nxt     = ST_LOAD;
                        remaining_nxt = len_q;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // Underrun simply waits here with prog_clk low
                if (!empty) begin
                    pop           = 1'b1;
                    shreg_nxt     = fifo_mem[rd_ptr_q];
                    bitcnt_nxt    = 5'd31;
                    phase_cnt_nxt = div_q;
                    state_nxt     = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_cnt_q == '0) begin
                    phase_cnt_nxt = div_q;
                    state_nxt     = ST_SHIFT_HI;
                end else begin
                    phase_cnt_nxt = phase_cnt_q - DIV_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (phase_cnt_q == '0) begin
                    remaining_nxt = remaining_q - LEN_W'(1);
                    shreg_nxt     = {shreg_q[30:0], 1'b0};
                    if (remaining_q == LEN_W'(1)) begin
                        state_nxt = ST_DONE;
                        done_set  = 1'b1;
                    end else if (bitcnt_q == 5'd0) begin
                        state_nxt = ST_LOAD;
                    end else begin
                        bitcnt_nxt    = bitcnt_q - 5'd1;
                        phase_cnt_nxt = div_q;
                        state_nxt     = ST_SHIFT_LO;
                    end
                end else begin
                    phase_cnt_nxt = phase_cnt_q - DIV_W'(1);
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            pop       = 1'b0;
            done_set  = 1'b0;
        end
    end

    // FIFO storage (no reset needed; validity tracked by level)
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_ni && push_ok) fifo_mem[wr_ptr_q] <= wbs_dat_i;
    end

    // Registers, FIFO pointers and registered outputs
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q       <= 1'b0;
            dat_q       <= 32'd0;
            div_q       <= '0;
            len_q       <= '0;
            tail_q      <= 32'd0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            preset_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            shreg_q     <= 32'd0;
            bitcnt_q    <= 5'd0;
            remaining_q <= '0;
            phase_cnt_q <= '0;
            pclk_q      <= 1'b0;
            head_q      <= 1'b0;
            hi_entry_q  <= 1'b0;
        end else begin
            ack_q <= bus_req & ~ack_q;
            dat_q <= (bus_req && !ack_q && !wbs_we_i) ? rd_mux : 32'd0;

            if (cfg_wr) begin
                div_q <= DIV_W'(cfg_new);
                len_q <= LEN_W'(cfg_new >> LEN_LSB);
            end
            if (ctrl_wr) preset_q <= wbs_dat_i[3];

            if (done_set)       done_q <= 1'b1;
            else if (clr_flags) done_q <= 1'b0;

            if (data_wr && !abort && !push_ok) ovf_q <= 1'b1;
            else if (clr_flags)                ovf_q <= 1'b0;

            if (abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop);
            end

            shreg_q     <= shreg_nxt;
            bitcnt_q    <= bitcnt_nxt;
            remaining_q <= remaining_nxt;
            phase_cnt_q <= phase_cnt_nxt;

            // Outputs follow the next state so they line up with the state they belong to
            pclk_q     <= (state_nxt == ST_SHIFT_HI);
            hi_entry_q <= (state_nxt == ST_SHIFT_HI) && (state_q != ST_SHIFT_HI);
            if (abort)                          head_q <= 1'b0;
            else if (state_nxt == ST_SHIFT_LO)  head_q <= shreg_nxt[31];

            // Sample the tail during the first cycle of prog_clk high
            if (hi_entry_q) tail_q <= {tail_q[30:0], ccff_tail_i};
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign prog_clk_o   = pclk_q;
    assign ccff_head_o  = head_q;
    assign prog_reset_o = preset_q;
    assign irq_o        = done_q;

endmodule

// File: tb/tb_wb_ccff_loader.sv
// Scoreboard bench for wb_ccff_loader: read expectations and expected serial
// bits are queued by the stimulus; a monitor checks them as acks and prog_clk
// rising edges appear.
module tb_wb_ccff_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w, dat_r;
    logic        ack, pclk, head, tail_in, preset, irq;
    logic        loop_en, tb_tail;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;

    logic [31:0] rd_exp_q[$];
    logic [31:0] rd_mask_q[$];
    string       rd_name_q[$];
    bit          bit_exp_q[$];
    int          gap_exp_q[$];

    localparam logic [1:0] A_CTRL = 2'd0, A_DATA = 2'd1, A_CFG = 2'd2, A_TAIL = 2'd3;

    assign tail_in = loop_en ? head : tb_tail;

    always #5 clk = ~clk;

    wb_ccff_loader dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_w),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_r),
        .prog_clk_o  (pclk),
        .ccff_head_o (head),
        .ccff_tail_i (tail_in),
        .prog_reset_o(preset),
        .irq_o       (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = {28'd0, a, 2'b00}; dat_w = d; sel = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 16);
        if (!ack) fail_now("ack_timeout");
        @(negedge clk);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        wb_xfer(1'b1, a, d, 4'hF);
    endtask

    task automatic wb_read(input string name, input logic [1:0] a, input logic [31:0] exp);
        rd_exp_q.push_back(exp);
        rd_mask_q.push_back(32'hFFFF_FFFF);
        rd_name_q.push_back(name);
        wb_xfer(1'b0, a, 32'd0, 4'hF);
    endtask

    // Queue expected head bits; gap is the expected cycle distance between rising edges
    task automatic push_word(input logic [31:0] w, input int nbits, input int div, input int base);
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = base + i;
            bit_exp_q.push_back(w[31-i]);
            if (idx == 0)           gap_exp_q.push_back(0);
            else if (idx % 32 == 0) gap_exp_q.push_back(2*(div+1) + 1);
            else                    gap_exp_q.push_back(2*(div+1));
        end
    endtask

    task automatic wait_irq(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!irq && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!irq) fail_now(name);
    endtask

    task automatic wait_pulses(input string name, input int target, input int max_cyc);
        int n;
        n = 0;
        while (pulse_cnt < target && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (pulse_cnt < target) fail_now(name);
    endtask

    // Monitor: read data on acks, head bit and period on prog_clk rising edges
    initial begin : monitor
        int   cyc_n;
        int   last_rise;
        logic pclk_prev;
        cyc_n = 0; last_rise = 0; pclk_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (ack && !we) begin
                if (rd_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read_ack: got 0x%08h, want no ack", dat_r);
                end else begin
                    logic [31:0] e, m;
                    string nm;
                    e = rd_exp_q.pop_front();
                    m = rd_mask_q.pop_front();
                    nm = rd_name_q.pop_front();
                    check(nm, dat_r & m, e & m);
                end
            end
            if (ack && we) check("write_ack_dat_zero", dat_r, 32'd0);
            if (pclk && !pclk_prev) begin
                pulse_cnt++;
                if (bit_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_prog_clk_pulse: got pulse %0d, want none", pulse_cnt);
                end else begin
                    bit b;
                    int g;
                    b = bit_exp_q.pop_front();
                    g = gap_exp_q.pop_front();
                    check("head_bit", 32'(head), 32'(b));
                    if (g != 0) check("prog_clk_period", 32'(cyc_n - last_rise), 32'(g));
                end
                last_rise = cyc_n;
            end
            pclk_prev = pclk;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int snap;
        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'd0; dat_w = 32'd0; loop_en = 1'b0; tb_tail = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_outputs", {27'd0, pclk, head, preset, irq, 1'b0}, 32'd0);
        check("rst_dat", dat_r, 32'd0);
        rst_n = 1'b1;
        wb_read("rst_status", A_CTRL, 32'h0000_2000);
        wb_read("rst_cfg", A_CFG, 32'd0);
        wb_read("rst_tail", A_TAIL, 32'd0);

        // prog_reset level control
        wb_write(A_CTRL, 32'h8);
        check("prog_reset_set", 32'(preset), 32'd1);
        wb_read("status_prog_reset", A_CTRL, 32'h0000_2008);
        wb_write(A_CTRL, 32'h0);
        check("prog_reset_clr", 32'(preset), 32'd0);

        // DIV=0, LEN=8, 0xA5000000, tail held high
        tb_tail = 1'b1;
        wb_write(A_CFG, 32'h0000_0800);
        wb_write(A_DATA, 32'hA500_0000);
        wb_read("status_level1", A_CTRL, 32'h0000_0100);
        push_word(32'hA500_0000, 8, 0, 0);
        wb_write(A_CTRL, 32'h1);
        wait_irq("a5_done_timeout", 200);
        check("a5_irq", 32'(irq), 32'd1);
        check("a5_all_bits", 32'(bit_exp_q.size()), 32'd0);
        wb_read("a5_status", A_CTRL, 32'h0000_2002);
        wb_read("a5_tail", A_TAIL, 32'h0000_00FF);
        wb_write(A_CTRL, 32'h4);
        check("a5_irq_clr", 32'(irq), 32'd0);
        tb_tail = 1'b0;

        // Loopback, LEN=64, DIV=3
        loop_en = 1'b1;
        wb_write(A_CFG, 32'h0000_4003);
        wb_write(A_DATA, 32'hDEAD_BEEF);
        wb_write(A_DATA, 32'h1234_5678);
        push_word(32'hDEAD_BEEF, 32, 3, 0);
        push_word(32'h1234_5678, 32, 3, 32);
        wb_write(A_CTRL, 32'h1);
        wait_irq("loop_done_timeout", 1500);
        check("loop_all_bits", 32'(bit_exp_q.size()), 32'd0);
        wb_read("loop_tail", A_TAIL, 32'h1234_5678);
        wb_write(A_CTRL, 32'h4);
        loop_en = 1'b0;

        // Underrun: start with empty FIFO, push 20 cycles later
        wb_write(A_CFG, 32'h0000_2000);
        snap = pulse_cnt;
        wb_write(A_CTRL, 32'h1);
        repeat (20) @(negedge clk);
        check("underrun_no_pulse", 32'(pulse_cnt - snap), 32'd0);
        check("underrun_pclk_low", 32'(pclk), 32'd0);
        wb_read("underrun_status", A_CTRL, 32'h0000_2001);
        push_word(32'h3C96_A50F, 32, 0, 0);
        wb_write(A_DATA, 32'h3C96_A50F);
        wait_irq("underrun_done_timeout", 300);
        check("underrun_all_bits", 32'(bit_exp_q.size()), 32'd0);
        wb_read("underrun_status_done", A_CTRL, 32'h0000_2002);
        wb_write(A_CTRL, 32'h4);

        // Overflow: 9 pushes into 8 entries
        for (int i = 0; i < 9; i++) wb_write(A_DATA, 32'h1111_1111 * 32'(i));
        wb_read("ovf_status", A_CTRL, 32'h0000_1804);
        wb_write(A_CTRL, 32'h4);
        wb_read("ovf_cleared", A_CTRL, 32'h0000_1800);
        wb_write(A_CTRL, 32'h2);
        wb_read("abort_flush", A_CTRL, 32'h0000_2000);

        // Abort mid-word at DIV=2
        wb_write(A_CFG, 32'h0000_2002);
        wb_write(A_DATA, 32'hF0F0_F0F0);
        push_word(32'hF0F0_F0F0, 32, 2, 0);
        snap = pulse_cnt;
        wb_write(A_CTRL, 32'h1);
        wait_pulses("abort_pulses_timeout", snap + 5, 200);
        wb_write(A_CTRL, 32'h2);
        check("abort_pclk_low", 32'(pclk), 32'd0);
        check("abort_head_low", 32'(head), 32'd0);
        bit_exp_q.delete();
        gap_exp_q.delete();
        snap = pulse_cnt;
        wb_read("abort_status", A_CTRL, 32'h0000_2000);
        repeat (40) @(negedge clk);
        check("abort_no_pulses", 32'(pulse_cnt - snap), 32'd0);

        // Reset mid-shift
        wb_write(A_DATA, 32'hCCCC_3333);
        push_word(32'hCCCC_3333, 32, 2, 0);
        snap = pulse_cnt;
        wb_write(A_CTRL, 32'h1);
        wait_pulses("reset_pulses_timeout", snap + 3, 200);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_pclk_low", 32'(pclk), 32'd0);
        check("reset_head_low", 32'(head), 32'd0);
        rst_n = 1'b1;
        bit_exp_q.delete();
        gap_exp_q.delete();
        snap = pulse_cnt;
        wb_read("reset_status", A_CTRL, 32'h0000_2000);
        wb_read("reset_cfg", A_CFG, 32'd0);
        repeat (40) @(negedge clk);
        check("reset_no_pulses", 32'(pulse_cnt - snap), 32'd0);

        // LEN=0 start, then CFG write while busy
        snap = pulse_cnt;
        wb_write(A_CTRL, 32'h1);
        wb_read("len0_status", A_CTRL, 32'h0000_2002);
        check("len0_irq", 32'(irq), 32'd1);
        check("len0_no_pulses", 32'(pulse_cnt - snap), 32'd0);
        wb_write(A_CTRL, 32'h4);
        wb_write(A_CFG, 32'h0000_2001);
        wb_write(A_CTRL, 32'h1);
        wb_read("busy_status", A_CTRL, 32'h0000_2001);
        wb_write(A_CFG, 32'h0000_0505);
        wb_read("cfg_busy_ignored", A_CFG, 32'h0000_2001);
        wb_write(A_CTRL, 32'h2);
        wb_read("busy_abort_status", A_CTRL, 32'h0000_2000);

        // Byte-select writes to CFG and other readback values
        wb_xfer(1'b1, A_CFG, 32'hFFFF_FFFF, 4'b0001);
        wb_read("cfg_sel0", A_CFG, 32'h0000_20FF);
        wb_xfer(1'b1, A_CFG, 32'h00AB_CD00, 4'b0110);
        wb_read("cfg_sel12", A_CFG, 32'h00AB_CDFF);
        wb_xfer(1'b1, A_CFG, 32'hFF00_0000, 4'b1000);
        wb_read("cfg_sel3_len_top", A_CFG, 32'h0FAB_CDFF);
        wb_read("data_reads_zero", A_DATA, 32'd0);
        wb_write(A_TAIL, 32'hFFFF_FFFF);
        wb_read("tail_write_ignored", A_TAIL, 32'd0);

        repeat (4) @(negedge clk);
        check("reads_all_acked", 32'(rd_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
